// File: rtl/cpu_exc_pkg.sv
// rtl/cpu_exc_pkg.sv - shared ExcCode constants and exception sequencer state encoding
package cpu_exc_pkg;

    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAVE   = 3'd1,
        ST_VECTOR = 3'd2,
        ST_ERET   = 3'd3,
        ST_RETURN = 3'd4
    } exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority exception request to ExcCode encoder
module exc_prio_enc
    import cpu_exc_pkg::*;
(
    input  logic [3:0] req_i,
    output logic       valid_o,
    output logic [4:0] code_o
);

    // Request bits: [0] syscall, [1] break, [2] reserved insn, [3] overflow.
    always_comb begin
        valid_o = |req_i;
        code_o  = 5'd0;
        if (req_i[2]) begin
            code_o = EXC_RI;
        end else if (req_i[3]) begin
            code_o = EXC_OV;
        end else if (req_i[0]) begin
            code_o = EXC_SYS;
        end else if (req_i[1]) begin
            code_o = EXC_BP;
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - exception entry / ERET return sequencer for the multi-cycle core
module exc_sequencer
    import cpu_exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100,
    parameter int          CNT_W        = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             insn_boundary,
    input  logic [3:0]       exc_req,
    input  logic [31:0]      exc_pc,
    input  logic             eret_req,
    input  logic [31:0]      epc_in,
    input  logic             status_exl,
    output logic             cp0_wen,
    output logic [31:0]      cp0_epc,
    output logic [4:0]       cp0_exccode,
    output logic             eret_executed,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic             cpu_stall,
    output logic             double_fault,
    output logic [CNT_W-1:0] exc_count
);

    exc_state_e       state_q, state_d;
    logic [31:0]      epc_q, epc_d;
    logic [4:0]       code_q, code_d;
    logic             df_q, df_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             enc_valid;
    logic [4:0]       enc_code;

    exc_prio_enc u_prio (
        .req_i   (exc_req),
        .valid_o (enc_valid),
        .code_o  (enc_code)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            epc_q   <= 32'd0;
            code_q  <= 5'd0;
            df_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            code_q  <= code_d;
            df_q    <= df_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        code_d        = code_q;
        df_d          = df_q;
        cnt_d         = cnt_q;
        cp0_wen       = 1'b0;
        cp0_epc       = 32'd0;
        cp0_exccode   = 5'd0;
        eret_executed = 1'b0;
        pc_redirect   = 1'b0;
        pc_target     = 32'd0;
        cpu_stall     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (insn_boundary) begin
                    if (enc_valid && !status_exl) begin
                        epc_d   = exc_pc;
                        code_d  = enc_code;
                        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                        state_d = ST_SAVE;
                    end else begin
                        // A request while EXL=1 is only flagged; a coincident ERET still runs.
                        if (enc_valid && status_exl) begin
                            df_d = 1'b1;
                        end
                        if (eret_req && status_exl) begin
                            state_d = ST_ERET;
                        end
                    end
                end
            end
            ST_SAVE: begin
                cp0_wen     = 1'b1;
                cp0_epc     = epc_q;
                cp0_exccode = code_q;
                cpu_stall   = 1'b1;
                state_d     = ST_VECTOR;
            end
            ST_VECTOR: begin
                pc_redirect = 1'b1;
                pc_target   = HANDLER_ADDR;
                cpu_stall   = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_ERET: begin
                eret_executed = 1'b1;
                cpu_stall     = 1'b1;
                epc_d         = epc_in;
                state_d       = ST_RETURN;
            end
            ST_RETURN: begin
                pc_redirect = 1'b1;
                pc_target   = epc_q;
                cpu_stall   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign double_fault = df_q;
    assign exc_count    = cnt_q;

endmodule
